// File: rtl/ras_driver_pkg.sv
// Shared CPU definitions for the return-address-stack producer: RAS entry
// type, control-transfer classes, MIPS opcode fields and FSM states.
package ras_driver_pkg;

  typedef struct packed {
    logic        valid;
    logic [32:0] data;
  } ras_t;

  typedef enum logic [1:0] {
    CTI_NONE,
    CTI_CALL,
    CTI_RET,
    CTI_OTHER
  } cti_kind_e;

  typedef enum logic [1:0] {
    IDLE,
    DS_CALL,
    DS_RET,
    DS_OTHER
  } ras_state_e;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_BLEZ    = 6'b000110;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;
  localparam logic [5:0] OP_BEQL    = 6'b010100;
  localparam logic [5:0] OP_BNEL    = 6'b010101;
  localparam logic [5:0] OP_BLEZL   = 6'b010110;
  localparam logic [5:0] OP_BGTZL   = 6'b010111;

  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_JALR    = 6'b001001;

  localparam logic [4:0] RT_BLTZ    = 5'b00000;
  localparam logic [4:0] RT_BGEZ    = 5'b00001;
  localparam logic [4:0] RT_BLTZL   = 5'b00010;
  localparam logic [4:0] RT_BGEZL   = 5'b00011;
  localparam logic [4:0] RT_BLTZAL  = 5'b10000;
  localparam logic [4:0] RT_BGEZAL  = 5'b10001;
  localparam logic [4:0] RT_BLTZALL = 5'b10010;
  localparam logic [4:0] RT_BGEZALL = 5'b10011;

  localparam logic [4:0] REG_RA     = 5'd31;

endpackage

// File: rtl/ras_predecode.sv
// Combinational classifier of a MIPS instruction word into call, return,
// other control transfer, or none.
module ras_predecode
  import ras_driver_pkg::*;
(
  input  logic [31:0] if_instr,
  output cti_kind_e   kind
);

  logic [5:0] op;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;
  logic [5:0] funct;
  logic [4:0] unused_shamt;

  assign op           = if_instr[31:26];
  assign rs           = if_instr[25:21];
  assign rt           = if_instr[20:16];
  assign rd           = if_instr[15:11];
  assign funct        = if_instr[5:0];
  assign unused_shamt = if_instr[10:6];

  always_comb begin
    kind = CTI_NONE;
    case (op)
      OP_SPECIAL: begin
        if (funct == FN_JR)
          kind = (rs == REG_RA) ? CTI_RET : CTI_OTHER;
        else if (funct == FN_JALR)
          kind = (rd != '0) ? CTI_CALL : CTI_OTHER;
      end
      OP_REGIMM: begin
        case (rt)
          RT_BLTZAL, RT_BGEZAL: kind = CTI_CALL;
          // Link-likely forms are not tracked as calls.
          RT_BLTZ, RT_BGEZ, RT_BLTZL, RT_BGEZL,
          RT_BLTZALL, RT_BGEZALL: kind = CTI_OTHER;
          default: kind = CTI_NONE;
        endcase
      end
      OP_JAL: kind = CTI_CALL;
      OP_J, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ,
      OP_BEQL, OP_BNEL, OP_BLEZL, OP_BGTZL: kind = CTI_OTHER;
      default: kind = CTI_NONE;
    endcase
  end

endmodule

// File: rtl/ras_driver.sv
// Fetch-stage RAS producer: predecodes accepted instructions, issues registered
// push/pop requests, redirects returns after the delay slot, tracks depth.
module ras_driver
  import ras_driver_pkg::*;
#(
  parameter int unsigned ENTRIES_NUM = 8
) (
  input  logic                               clk,
  input  logic                               resetn,
  input  logic                               flush,
  input  logic                               if_valid,
  input  logic                               if_ready,
  input  logic [31:0]                        if_pc,
  input  logic [31:0]                        if_instr,
  input  ras_t                               ras_top,
  output logic                               push_req,
  output logic                               pop_req,
  output logic [32:0]                        push_data,
  output logic                               pred_valid,
  output logic [31:0]                        pred_target,
  output logic [$clog2(ENTRIES_NUM+1)-1:0]   depth
);

  localparam int unsigned      DW        = $clog2(ENTRIES_NUM + 1);
  localparam logic [DW-1:0]    DEPTH_MAX = DW'(ENTRIES_NUM);

  ras_state_e state_q, state_d;
  cti_kind_e  kind;
  logic       accept;
  logic       hit_q;
  logic       do_push, do_pop, do_redirect;
  logic       unused_top_msb;

  assign accept         = if_valid & if_ready;
  assign unused_top_msb = ras_top.data[32];

  ras_predecode u_predecode (
    .if_instr (if_instr),
    .kind     (kind)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Delay-slot instructions are never classified: any accept in a DS_* state
  // simply returns to IDLE, with DS_RET releasing the captured redirect.
  always_comb begin
    state_d     = state_q;
    do_push     = 1'b0;
    do_pop      = 1'b0;
    do_redirect = 1'b0;
    if (flush) begin
      state_d = IDLE;
    end else if (accept) begin
      case (state_q)
        IDLE: begin
          case (kind)
            CTI_CALL:  begin state_d = DS_CALL; do_push = 1'b1; end
            CTI_RET:   begin state_d = DS_RET;  do_pop  = 1'b1; end
            CTI_OTHER: state_d = DS_OTHER;
            default:   state_d = IDLE;
          endcase
        end
        DS_RET: begin
          state_d     = IDLE;
          do_redirect = hit_q;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      push_req    <= 1'b0;
      pop_req     <= 1'b0;
      push_data   <= '0;
      pred_valid  <= 1'b0;
      pred_target <= '0;
      hit_q       <= 1'b0;
      depth       <= '0;
    end else begin
      push_req   <= do_push;
      pop_req    <= do_pop;
      pred_valid <= do_redirect;
      if (do_push) push_data <= {1'b0, if_pc + 32'd8};
      if (do_pop) begin
        pred_target <= ras_top.data[31:0];
        hit_q       <= ras_top.valid;
      end
      if (flush)
        depth <= '0;
      else if (do_push && depth != DEPTH_MAX)
        depth <= depth + DW'(1);
      else if (do_pop && depth != '0)
        depth <= depth - DW'(1);
    end
  end

endmodule

// File: tb/tb_ras_driver.sv
// Directed self-checking bench for ras_driver with hand-computed expectations.
module tb_ras_driver;
  import ras_driver_pkg::*;

  localparam logic [31:0] I_JAL   = 32'h0C00_0000;
  localparam logic [31:0] I_JR31  = 32'h03E0_0008;
  localparam logic [31:0] I_BEQ   = 32'h1000_0000;
  localparam logic [31:0] I_NOP   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        flush = 1'b0;
  logic        if_valid = 1'b0;
  logic        if_ready = 1'b1;
  logic [31:0] if_pc = '0;
  logic [31:0] if_instr = '0;
  ras_t        ras_top = '0;
  logic        push_req, pop_req, pred_valid;
  logic [32:0] push_data;
  logic [31:0] pred_target;
  logic [3:0]  depth;

  int checks = 0;
  int failures = 0;

  ras_driver #(.ENTRIES_NUM(8)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .flush       (flush),
    .if_valid    (if_valid),
    .if_ready    (if_ready),
    .if_pc       (if_pc),
    .if_instr    (if_instr),
    .ras_top     (ras_top),
    .push_req    (push_req),
    .pop_req     (pop_req),
    .push_data   (push_data),
    .pred_valid  (pred_valid),
    .pred_target (pred_target),
    .depth       (depth)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins);
    if_valid = v;
    if_pc    = pc;
    if_instr = ins;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (push_req !== 1'b0) begin failures++; $display("FAIL reset_push got=%b exp=0", push_req); end
    checks++; if (pop_req !== 1'b0) begin failures++; $display("FAIL reset_pop got=%b exp=0", pop_req); end
    checks++; if (push_data !== 33'h0) begin failures++; $display("FAIL reset_push_data got=%h exp=0", push_data); end
    checks++; if (pred_valid !== 1'b0) begin failures++; $display("FAIL reset_pred_valid got=%b exp=0", pred_valid); end
    checks++; if (pred_target !== 32'h0) begin failures++; $display("FAIL reset_pred_target got=%h exp=0", pred_target); end
    checks++; if (depth !== 4'd0) begin failures++; $display("FAIL reset_depth got=%0d exp=0", depth); end
    resetn = 1'b1;
    step();
  endtask

  task automatic test_call();
    drive(1'b1, 32'h8000_1000, I_JAL);
    step();
    checks++; if (push_req !== 1'b1) begin failures++; $display("FAIL call_push got=%b exp=1", push_req); end
    checks++; if (push_data !== 33'h0_8000_1008) begin failures++; $display("FAIL call_push_data got=%h exp=080001008", push_data); end
    checks++; if (depth !== 4'd1) begin failures++; $display("FAIL call_depth got=%0d exp=1", depth); end
    drive(1'b1, 32'h8000_1004, I_JAL);
    step();
    checks++; if (push_req !== 1'b0) begin failures++; $display("FAIL call_ds_push got=%b exp=0", push_req); end
    checks++; if (depth !== 4'd1) begin failures++; $display("FAIL call_ds_depth got=%0d exp=1", depth); end
    drive(1'b0, '0, I_NOP);
    step();
  endtask

  task automatic test_return_hit();
    ras_top = '{valid: 1'b1, data: 33'h0_8000_1008};
    drive(1'b1, 32'hBFC0_0100, I_JR31);
    step();
    checks++; if (pop_req !== 1'b1) begin failures++; $display("FAIL ret_pop got=%b exp=1", pop_req); end
    checks++; if (depth !== 4'd0) begin failures++; $display("FAIL ret_depth got=%0d exp=0", depth); end
    drive(1'b1, 32'hBFC0_0104, I_NOP);
    if_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (pop_req !== 1'b0 || pred_valid !== 1'b0) begin
        failures++; $display("FAIL ret_stall%0d got pop=%b pv=%b exp 0 0", i, pop_req, pred_valid);
      end
    end
    if_ready = 1'b1;
    step();
    checks++; if (pred_valid !== 1'b1) begin failures++; $display("FAIL ret_pred_valid got=%b exp=1", pred_valid); end
    checks++; if (pred_target !== 32'h8000_1008) begin failures++; $display("FAIL ret_pred_target got=%h exp=80001008", pred_target); end
    drive(1'b0, '0, I_NOP);
    step();
    checks++; if (pred_valid !== 1'b0) begin failures++; $display("FAIL ret_pred_pulse got=%b exp=0", pred_valid); end
  endtask

  task automatic test_return_miss();
    ras_top = '{valid: 1'b0, data: 33'h0_1234_5678};
    drive(1'b1, 32'h0000_2000, I_JR31);
    step();
    checks++; if (pop_req !== 1'b1) begin failures++; $display("FAIL miss_pop got=%b exp=1", pop_req); end
    checks++; if (depth !== 4'd0) begin failures++; $display("FAIL miss_depth got=%0d exp=0", depth); end
    drive(1'b1, 32'h0000_2004, I_NOP);
    step();
    checks++; if (pred_valid !== 1'b0) begin failures++; $display("FAIL miss_pred_ds got=%b exp=0", pred_valid); end
    drive(1'b0, '0, I_NOP);
    step();
    checks++; if (pred_valid !== 1'b0) begin failures++; $display("FAIL miss_pred_after got=%b exp=0", pred_valid); end
  endtask

  task automatic test_ds_ignored();
    drive(1'b1, 32'h0000_3000, I_BEQ);
    step();
    checks++; if (push_req !== 1'b0 || pop_req !== 1'b0) begin
      failures++; $display("FAIL beq_req got push=%b pop=%b exp 0 0", push_req, pop_req);
    end
    drive(1'b1, 32'h0000_3004, I_JAL);
    step();
    checks++; if (push_req !== 1'b0) begin failures++; $display("FAIL ds_jal_push got=%b exp=0", push_req); end
    drive(1'b1, 32'h0000_3008, I_JAL);
    step();
    checks++; if (push_req !== 1'b1) begin failures++; $display("FAIL next_jal_push got=%b exp=1", push_req); end
    checks++; if (push_data !== 33'h0_0000_3010) begin failures++; $display("FAIL next_jal_data got=%h exp=000003010", push_data); end
    drive(1'b1, 32'h0000_300C, I_NOP);
    step();
    drive(1'b0, '0, I_NOP);
  endtask

  typedef struct {
    logic [31:0] ins;
    cti_kind_e   k;
  } pd_vec_t;

  task automatic test_predecode_classes();
    pd_vec_t v[12];
    v[0]  = '{32'h00A0_F809, CTI_CALL};   // jalr $31,$5
    v[1]  = '{32'h00A0_0009, CTI_OTHER};  // jalr rd=0
    v[2]  = '{32'h00A0_0008, CTI_OTHER};  // jr $5
    v[3]  = '{32'h0411_0000, CTI_CALL};   // bgezal
    v[4]  = '{32'h0410_0000, CTI_CALL};   // bltzal
    v[5]  = '{32'h0400_0000, CTI_OTHER};  // bltz
    v[6]  = '{32'h5400_0000, CTI_OTHER};  // bnel
    v[7]  = '{32'h0413_0000, CTI_OTHER};  // bgezall
    v[8]  = '{32'h0800_0000, CTI_OTHER};  // j
    v[9]  = '{32'h0000_0021, CTI_NONE};   // addu
    v[10] = '{32'h1C00_0000, CTI_OTHER};  // bgtz
    v[11] = '{32'h03E0_0008, CTI_RET};    // jr $31
    ras_top = '{valid: 1'b0, data: 33'h0};
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 32'h0000_4000, v[i].ins);
      step();
      checks++; if (push_req !== (v[i].k == CTI_CALL) || pop_req !== (v[i].k == CTI_RET)) begin
        failures++; $display("FAIL pd%0d_req got push=%b pop=%b exp push=%b pop=%b",
                             i, push_req, pop_req, v[i].k == CTI_CALL, v[i].k == CTI_RET);
      end
      drive(1'b1, 32'h0000_4004, I_JAL);
      step();
      checks++; if (push_req !== (v[i].k == CTI_NONE)) begin
        failures++; $display("FAIL pd%0d_ds got push=%b exp=%b", i, push_req, v[i].k == CTI_NONE);
      end
      if (v[i].k == CTI_NONE) begin
        drive(1'b1, 32'h0000_4008, I_NOP);
        step();
      end
    end
    drive(1'b0, '0, I_NOP);
  endtask

  task automatic test_saturation();
    int pushes;
    logic [3:0] exp_d;
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (depth !== 4'd0) begin failures++; $display("FAIL sat_flush_depth got=%0d exp=0", depth); end
    pushes = 0;
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 32'h0000_5000 + 32'(i * 8), I_JAL);
      step();
      if (push_req === 1'b1) pushes++;
      exp_d = (i >= 7) ? 4'd8 : 4'(i + 1);
      checks++; if (depth !== exp_d) begin failures++; $display("FAIL sat_depth%0d got=%0d exp=%0d", i, depth, exp_d); end
      drive(1'b1, 32'h0000_5004 + 32'(i * 8), I_NOP);
      step();
      if (push_req === 1'b1) pushes++;
    end
    checks++; if (pushes !== 9) begin failures++; $display("FAIL sat_pushes got=%0d exp=9", pushes); end
    drive(1'b0, '0, I_NOP);
  endtask

  task automatic test_flush_and_reset();
    ras_top = '{valid: 1'b1, data: 33'h0_CAFE_0000};
    drive(1'b1, 32'h0000_6000, I_JR31);
    step();
    checks++; if (pop_req !== 1'b1 || depth !== 4'd7) begin
      failures++; $display("FAIL fl_pop got pop=%b depth=%0d exp 1 7", pop_req, depth);
    end
    flush = 1'b1;
    drive(1'b1, 32'h0000_6004, I_JAL);
    step();
    flush = 1'b0;
    checks++; if (push_req !== 1'b0 || pop_req !== 1'b0 || depth !== 4'd0) begin
      failures++; $display("FAIL fl_cycle got push=%b pop=%b depth=%0d exp 0 0 0", push_req, pop_req, depth);
    end
    drive(1'b1, 32'h0000_6008, I_NOP);
    step();
    checks++; if (pred_valid !== 1'b0 || depth !== 4'd0) begin
      failures++; $display("FAIL fl_ds got pv=%b depth=%0d exp 0 0", pred_valid, depth);
    end
    drive(1'b1, 32'h0000_7000, I_JAL);
    step();
    drive(1'b1, 32'h0000_7004, I_NOP);
    step();
    drive(1'b1, 32'h0000_7008, I_JR31);
    step();
    checks++; if (pop_req !== 1'b1 || pred_target !== 32'hCAFE_0000) begin
      failures++; $display("FAIL rst_pre got pop=%b tgt=%h exp 1 cafe0000", pop_req, pred_target);
    end
    drive(1'b1, 32'h0000_700C, I_NOP);
    if_ready = 1'b0;
    resetn = 1'b0;
    #1;
    checks++; if ({push_req, pop_req, pred_valid} !== 3'b000 || push_data !== 33'h0 ||
                  pred_target !== 32'h0 || depth !== 4'd0) begin
      failures++; $display("FAIL rst_async got push=%b pop=%b pv=%b data=%h tgt=%h depth=%0d exp all 0",
                           push_req, pop_req, pred_valid, push_data, pred_target, depth);
    end
    #1;
    resetn = 1'b1;
    if_ready = 1'b1;
    drive(1'b1, 32'h0000_8000, I_JAL);
    step();
    checks++; if (push_req !== 1'b1 || push_data !== 33'h0_0000_8008 || depth !== 4'd1) begin
      failures++; $display("FAIL rst_after got push=%b data=%h depth=%0d exp 1 000008008 1",
                           push_req, push_data, depth);
    end
    drive(1'b0, '0, I_NOP);
    step();
  endtask

  initial begin
    test_reset();
    test_call();
    test_return_hit();
    test_return_miss();
    test_ds_ignored();
    test_predecode_classes();
    test_saturation();
    test_flush_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
